datamem_arbiter: RTL and testbench

Shares the single-ported data memory (`datamem`) between the pipelined CPU's MEM stage and a burst DMA/debug requester. The CPU has priority by default. A starvation counter forces a DMA beat, and stalls the pipeline, after `STARVE_MAX` consecutive CPU wins. The block sits between the EX/MEM register outputs and `datamem`. It drives the pipeline stall that freezes PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/datamem_arbiter.sv | 145 ++++++++++++++
 tb/tb_datamem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU MEM stage and a burst DMA requester.
// The CPU wins by default; a starvation counter forces a stalled DMA beat every STARVE_MAX CPU wins.
module datamem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int BURST_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic [63:0]        cpu_addr,
  input  logic [63:0]        cpu_wdata,
  output logic [63:0]        cpu_rdata,
  output logic               cpu_stall,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [63:0]        dma_addr,
  input  logic [BURST_W-1:0] dma_len,
  output logic               dma_ack,
  input  logic [63:0]        dma_wdata,
  output logic               dma_wready,
  output logic               dma_rvalid,
  output logic [63:0]        dma_rdata,
  output logic               dma_done,
  output logic [63:0]        mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [63:0]        mem_wdata,
  output logic [3:0]         mem_xfer_size,
  input  logic [63:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FORCE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [63:0]        burst_addr_q, burst_addr_d;
  logic               burst_we_q, burst_we_d;
  logic [BURST_W:0]   remaining_q, remaining_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               rvalid_q, rvalid_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               done_q, done_d;

  logic               cpu_req;
  logic               dma_beat;
  logic               cpu_access;
  logic [3:0]         starve_inc;

  assign cpu_req    = cpu_re | cpu_we;
  assign dma_beat   = (state_q == FORCE) || ((state_q == BURST) && !cpu_req);
  assign cpu_access = cpu_req && ((state_q == IDLE) || (state_q == BURST));
  assign starve_inc = starve_cnt_q + 4'd1;

  assign cpu_rdata     = mem_rdata;
  assign cpu_stall     = (state_q == FORCE);
  assign dma_ack       = (state_q == IDLE) && dma_req && !rst;
  assign dma_wready    = dma_beat && burst_we_q;
  assign dma_rvalid    = rvalid_q;
  assign dma_rdata     = rdata_q;
  assign dma_done      = done_q;
  assign mem_xfer_size = 4'b1000;

  // Memory port routing: DMA beat, CPU access, or fully quiet.
  always_comb begin
    mem_addr  = 64'd0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 64'd0;
    if (dma_beat) begin
      mem_addr  = burst_addr_q;
      mem_we    = burst_we_q;
      mem_re    = ~burst_we_q;
      mem_wdata = dma_wdata;
    end else if (cpu_access) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_re    = cpu_re;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    burst_we_d   = burst_we_q;
    remaining_d  = remaining_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_req) begin
          burst_addr_d = dma_addr;
          burst_we_d   = dma_we;
          remaining_d  = {1'b0, dma_len} + {{BURST_W{1'b0}}, 1'b1};
          starve_cnt_d = 4'd0;
          state_d      = BURST;
        end
      end
      BURST, FORCE: begin
        if (!dma_beat) begin
          starve_cnt_d = starve_inc;
          if (starve_inc == 4'(STARVE_MAX)) state_d = FORCE;
        end else begin
          burst_addr_d = burst_addr_q + 64'd8;
          remaining_d  = remaining_q - {{BURST_W{1'b0}}, 1'b1};
          starve_cnt_d = 4'd0;
          rvalid_d     = ~burst_we_q;
          if (!burst_we_q) rdata_d = mem_rdata;
          if (remaining_q == {{BURST_W{1'b0}}, 1'b1}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = BURST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_addr_q <= 64'd0;
      burst_we_q   <= 1'b0;
      remaining_q  <= '0;
      starve_cnt_q <= 4'd0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 64'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      burst_we_q   <= burst_we_d;
      remaining_q  <= remaining_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: bursts, CPU interleave, starvation, wrap, reset, busy requests.
module tb_datamem_arbiter;

  localparam logic [63:0] K = 64'hA5A5_5A5A_0F0F_F0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [63:0] dma_addr;
  logic [3:0]  dma_len;
  logic        dma_ack;
  logic [63:0] dma_wdata;
  logic        dma_wready, dma_rvalid;
  logic [63:0] dma_rdata;
  logic        dma_done;
  logic [63:0] mem_addr;
  logic        mem_we, mem_re;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_rdata;

  int n_chk = 0;
  int n_pass = 0;

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ K;

  always #5 clk = ~clk;

  datamem_arbiter #(.STARVE_MAX(4), .BURST_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_ack(dma_ack), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_xfer_size(mem_xfer_size), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    tick; tick;
    rst = 1'b0;
    settle;
    chk("rst_ack", {63'd0, dma_ack}, 64'd0);
    chk("rst_rvalid", {63'd0, dma_rvalid}, 64'd0);
    chk("rst_done", {63'd0, dma_done}, 64'd0);
    chk("rst_rdata", dma_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_rewe", {62'd0, mem_re, mem_we}, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
    chk("xfer_size", {60'd0, mem_xfer_size}, 64'd8);

    // Uncontended 4-beat read burst
    tick;
    dma_req = 1; dma_we = 0; dma_addr = 64'h100; dma_len = 4'd3;
    settle;
    chk("rd_ack", {63'd0, dma_ack}, 64'd1);
    for (int c = 1; c <= 5; c++) begin
      tick;
      dma_req = 0;
      settle;
      if (c <= 4) begin
        chk("rd_addr", mem_addr, 64'h100 + 64'(8 * (c - 1)));
        chk("rd_re", {63'd0, mem_re}, 64'd1);
      end else begin
        chk("rd_idle_addr", mem_addr, 64'd0);
      end
      chk("rd_stall", {63'd0, cpu_stall}, 64'd0);
      chk("rd_rvalid", {63'd0, dma_rvalid}, (c >= 2) ? 64'd1 : 64'd0);
      if (c >= 2) chk("rd_rdata", dma_rdata, (64'h100 + 64'(8 * (c - 2))) ^ K);
      chk("rd_done", {63'd0, dma_done}, (c == 5) ? 64'd1 : 64'd0);
    end

    // Write burst with one interleaved CPU write
    tick;
    dma_req = 1; dma_we = 1; dma_addr = 64'h200; dma_len = 4'd1;
    settle;
    chk("wr_ack", {63'd0, dma_ack}, 64'd1);
    tick;
    dma_req = 0; cpu_we = 1; cpu_addr = 64'h40; cpu_wdata = 64'hDEAD_BEEF;
    settle;
    chk("wr_cpu_addr", mem_addr, 64'h40);
    chk("wr_cpu_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("wr_cpu_we", {63'd0, mem_we}, 64'd1);
    chk("wr_cpu_wready", {63'd0, dma_wready}, 64'd0);
    tick;
    cpu_we = 0; dma_wdata = 64'h1111;
    settle;
    chk("wr_b0_addr", mem_addr, 64'h200);
    chk("wr_b0_data", mem_wdata, 64'h1111);
    chk("wr_b0_we_re", {62'd0, mem_we, mem_re}, 64'd2);
    chk("wr_b0_wready", {63'd0, dma_wready}, 64'd1);
    tick;
    dma_wdata = 64'h2222;
    settle;
    chk("wr_b1_addr", mem_addr, 64'h208);
    chk("wr_b1_data", mem_wdata, 64'h2222);
    chk("wr_b1_wready", {63'd0, dma_wready}, 64'd1);
    tick;
    settle;
    chk("wr_done", {63'd0, dma_done}, 64'd1);
    chk("wr_rvalid", {63'd0, dma_rvalid}, 64'd0);
    chk("wr_end_wready", {63'd0, dma_wready}, 64'd0);

    // Starvation under continuous CPU reads
    tick;
    dma_req = 1; dma_we = 0; dma_addr = 64'h300; dma_len = 4'd1;
    settle;
    chk("st_ack", {63'd0, dma_ack}, 64'd1);
    for (int c = 1; c <= 11; c++) begin
      tick;
      dma_req = 0; cpu_re = 1; cpu_addr = 64'h80;
      settle;
      if (c == 5) begin
        chk("st_f0_addr", mem_addr, 64'h300);
        chk("st_f0_stall", {63'd0, cpu_stall}, 64'd1);
      end else if (c == 10) begin
        chk("st_f1_addr", mem_addr, 64'h308);
        chk("st_f1_stall", {63'd0, cpu_stall}, 64'd1);
      end else begin
        chk("st_cpu_addr", mem_addr, 64'h80);
        chk("st_cpu_stall", {63'd0, cpu_stall}, 64'd0);
      end
      chk("st_rvalid", {63'd0, dma_rvalid}, (c == 6 || c == 11) ? 64'd1 : 64'd0);
      chk("st_done", {63'd0, dma_done}, (c == 11) ? 64'd1 : 64'd0);
    end
    chk("st_rdata", dma_rdata, 64'h308 ^ K);

    // Address wrap
    tick;
    cpu_re = 0; cpu_addr = 0;
    dma_req = 1; dma_we = 0; dma_addr = 64'hFFFF_FFFF_FFFF_FFF8; dma_len = 4'd1;
    settle;
    chk("wrap_ack", {63'd0, dma_ack}, 64'd1);
    tick;
    dma_req = 0;
    settle;
    chk("wrap_b0", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick;
    settle;
    chk("wrap_b1", mem_addr, 64'd0);
    chk("wrap_b1_re", {63'd0, mem_re}, 64'd1);
    tick;
    settle;
    chk("wrap_done", {63'd0, dma_done}, 64'd1);
    chk("wrap_rdata", dma_rdata, 64'd0 ^ K);

    // Reset on the second beat of a 4-beat read
    tick;
    dma_req = 1; dma_we = 0; dma_addr = 64'h400; dma_len = 4'd3;
    tick;
    dma_req = 0;
    settle;
    chk("rr_b0", mem_addr, 64'h400);
    tick;
    rst = 1;
    tick;
    rst = 0;
    settle;
    chk("rr_rvalid", {63'd0, dma_rvalid}, 64'd0);
    chk("rr_done", {63'd0, dma_done}, 64'd0);
    chk("rr_addr", mem_addr, 64'd0);
    chk("rr_rdata", dma_rdata, 64'd0);
    tick;
    settle;
    chk("rr_idle_addr", mem_addr, 64'd0);
    chk("rr_idle_done", {63'd0, dma_done}, 64'd0);
    chk("rr_idle_rvalid", {63'd0, dma_rvalid}, 64'd0);

    // Second request while busy is held off until done
    tick;
    dma_req = 1; dma_we = 0; dma_addr = 64'h500; dma_len = 4'd1;
    settle;
    chk("bz_ack0", {63'd0, dma_ack}, 64'd1);
    tick;
    dma_addr = 64'h600; dma_len = 4'd0;
    settle;
    chk("bz_c1_ack", {63'd0, dma_ack}, 64'd0);
    chk("bz_c1_addr", mem_addr, 64'h500);
    tick;
    settle;
    chk("bz_c2_ack", {63'd0, dma_ack}, 64'd0);
    chk("bz_c2_addr", mem_addr, 64'h508);
    tick;
    settle;
    chk("bz_c3_done", {63'd0, dma_done}, 64'd1);
    chk("bz_c3_ack", {63'd0, dma_ack}, 64'd1);
    tick;
    dma_req = 0;
    settle;
    chk("bz_c4_addr", mem_addr, 64'h600);
    chk("bz_c4_done", {63'd0, dma_done}, 64'd0);
    tick;
    settle;
    chk("bz_c5_done", {63'd0, dma_done}, 64'd1);
    chk("bz_c5_rdata", dma_rdata, 64'h600 ^ K);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
